// File: rtl/mem_block_mover_if.sv
// Control and memory-bus bundle for mem_block_mover.
//   master: the mover (consumes go/fill/addresses/length/fill_value/abort and
//           mem_data_in; drives busy, done and the memory strobes/address/data).
//   slave : the controller plus data memory side of the same signals.
interface mem_block_mover_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              go;
  logic              fill;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] length;
  logic [DATA_W-1:0] fill_value;
  logic              abort;
  logic              busy;
  logic              done;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    input  go, fill, src_addr, dst_addr, length, fill_value, abort, mem_data_in,
    output busy, done, mem_read, mem_write, mem_address, mem_data_out
  );

  modport slave (
    output go, fill, src_addr, dst_addr, length, fill_value, abort, mem_data_in,
    input  busy, done, mem_read, mem_write, mem_address, mem_data_out
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / block fill initiator for the 8-bit data memory.
// Ports:
//   clock   - system clock, rising-edge state updates
//   reset_n - asynchronous active-low reset
//   bus     - mem_block_mover_if.master: start/abort control, transfer
//             parameters, busy/done status and the memory strobes/address/data.
// Copy alternates READ (capture byte into hold) and WRITE; fill stays in WRITE.
// All outputs are decoded from state and registers only.
module mem_block_mover #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic                clock,
  input logic                reset_n,
  mem_block_mover_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic              fill_q, fill_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fval_q, fval_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      fill_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fval_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fval_q  <= fval_d;
      hold_q  <= hold_d;
    end
  end

  // Next state and register updates.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fval_d  = fval_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        // go has priority over abort here; abort is simply not looked at.
        if (bus.go) begin
          fill_d = bus.fill;
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          cnt_d  = bus.length;
          fval_d = bus.fill_value;
          if (bus.length == '0) begin
            state_d = StDone;
          end else if (bus.fill) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          hold_d  = bus.mem_data_in;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // The write strobe is already up this cycle, so the byte lands even on abort.
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - ADDR_W'(1);
        if (bus.abort) begin
          state_d = StIdle;
        end else if (cnt_q == ADDR_W'(1)) begin
          state_d = StDone;
        end else if (fill_q) begin
          state_d = StWrite;
        end else begin
          state_d = StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs.
  always_comb begin
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_address  = '0;
    bus.mem_data_out = '0;
    unique case (state_q)
      StRead: begin
        bus.busy        = 1'b1;
        bus.mem_read    = 1'b1;
        bus.mem_address = src_q;
      end
      StWrite: begin
        bus.busy         = 1'b1;
        bus.mem_write    = 1'b1;
        bus.mem_address  = dst_q;
        bus.mem_data_out = fill_q ? fval_q : hold_q;
      end
      StDone: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_block_mover.sv
module tb_mem_block_mover;

  logic clock;
  logic reset_n;

  mem_block_mover_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: combinational read, commit on falling edge.
  logic [7:0]  mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [16:0] log_q [$];  // {is_write, address, data}
  int          busy_cnt;
  int          done_cnt;
  int          both_cnt;

  always_comb bus.mem_data_in = bus.mem_read ? mem[bus.mem_address] : 8'h00;

  always @(negedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else begin
      if (bus.mem_write) begin
        mem[bus.mem_address] <= bus.mem_data_out;
        log_q.push_back({1'b1, bus.mem_address, bus.mem_data_out});
      end
      if (bus.mem_read) log_q.push_back({1'b0, bus.mem_address, 8'h00});
      if (bus.mem_read && bus.mem_write) both_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
    end
  end

  int n_pass;
  int n_total;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clock);
    #1;
    ld_en = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {4'h0, bus.busy, bus.done, bus.mem_read, bus.mem_write,
            bus.mem_address, bus.mem_data_out, 8'h00};
  endfunction

  task automatic randomize_inputs();
    bus.fill       = 1'($urandom);
    bus.src_addr   = 8'($urandom);
    bus.dst_addr   = 8'($urandom);
    bus.length     = 8'($urandom);
    bus.fill_value = 8'($urandom);
  endtask

  // One transfer. abort_at > 0 raises abort in that WRITE cycle (counted from 1).
  task automatic run(input string tag, input logic f, input logic [7:0] s,
                     input logic [7:0] d, input logic [7:0] l, input logic [7:0] v,
                     input bit glitch, input int abort_at);
    logic [7:0]  ref_mem [256];
    logic [16:0] exp_q [$];
    logic [7:0]  val;
    int          nb, exp_busy, log0, done0, busy0, k, mism;

    // Reference: ascending byte-by-byte move over a snapshot of memory.
    ref_mem = mem;
    nb = (abort_at > 0) ? abort_at : int'(l);
    for (int i = 0; i < nb; i++) begin
      if (!f) begin
        exp_q.push_back({1'b0, s + 8'(i), 8'h00});
        val = ref_mem[s + 8'(i)];
      end else begin
        val = v;
      end
      ref_mem[d + 8'(i)] = val;
      exp_q.push_back({1'b1, d + 8'(i), val});
    end
    exp_busy = f ? nb : 2 * nb;

    log0  = log_q.size();
    done0 = done_cnt;
    busy0 = busy_cnt;

    bus.fill = f; bus.src_addr = s; bus.dst_addr = d; bus.length = l; bus.fill_value = v;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    randomize_inputs();

    if (abort_at > 0) begin
      for (int i = 0; i < exp_busy - 1; i++) step();
      check({tag, "_wr_before_abort"}, 32'(bus.mem_write), 32'd1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check({tag, "_idle_after_abort"}, outs(), 32'h0);
      step();
      step();
      check({tag, "_no_done"}, 32'(done_cnt - done0), 32'd0);
    end else begin
      k = 0;
      while (!bus.done && k < 600) begin
        if (glitch && k == 2) begin
          bus.go = 1'b1;
          randomize_inputs();
          bus.length = 8'd7;
        end else begin
          bus.go = 1'b0;
        end
        step();
        k++;
      end
      bus.go = 1'b0;
      check({tag, "_cycles_to_done"}, 32'(k), 32'(exp_busy));
      check({tag, "_done_high"}, 32'(bus.done), 32'd1);
      step();
      check({tag, "_idle_outputs"}, outs(), 32'h0);
      check({tag, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
    end

    check({tag, "_busy_cycles"}, 32'(busy_cnt - busy0), 32'(exp_busy));
    check({tag, "_access_count"}, 32'(log_q.size() - log0), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (log0 + i >= log_q.size()) mism++;
      else if (log_q[log0 + i] !== exp_q[i]) mism++;
    end
    check({tag, "_access_seq"}, 32'(mism), 32'd0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    check({tag, "_memory"}, 32'(mism), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    busy_cnt = 0; done_cnt = 0; both_cnt = 0;
    ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    bus.go = 1'b0; bus.abort = 1'b0;
    randomize_inputs();

    reset_n = 1'b0;
    step();
    step();
    check("reset_outputs", outs(), 32'h0);
    reset_n = 1'b1;
    step();

    // Directed copy.
    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    step();
    run("copy", 1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 1'b0, 0);
    check("copy_byte3", 32'(mem[8'h43]), 32'hD4);

    // Directed fill; byte past the end must stay.
    run("fill", 1'b1, 8'h00, 8'h80, 8'd3, 8'h5A, 1'b0, 0);
    check("fill_byte0", 32'(mem[8'h80]), 32'h5A);

    run("wrap", 1'b0, 8'hFE, 8'h20, 8'd4, 8'h00, 1'b0, 0);
    run("zero_len", 1'b0, 8'h33, 8'h44, 8'd0, 8'h00, 1'b0, 0);
    run("go_ignored", 1'b0, 8'h60, 8'hA0, 8'd5, 8'h00, 1'b1, 0);
    run("overlap", 1'b0, 8'h50, 8'h52, 8'd6, 8'h00, 1'b0, 0);
    run("abort", 1'b0, 8'h08, 8'hC0, 8'd10, 8'h00, 1'b0, 3);

    // Reset in the middle of a fill must clear outputs without a clock edge.
    bus.fill = 1'b1; bus.dst_addr = 8'h90; bus.length = 8'd20; bus.fill_value = 8'h3C;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    step(); step(); step();
    check("fill_busy_pre_reset", 32'(bus.busy), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    run("after_reset", 1'b1, 8'h00, 8'h70, 8'd5, 8'hE7, 1'b0, 0);

    // Randomized transfers against the reference model.
    for (int t = 0; t < 8; t++) begin
      run($sformatf("rand%0d", t), 1'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom_range(0, 30)), 8'($urandom), 1'($urandom), 0);
    end

    check("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Bus initiator for the 8-bit data memory. Drives its read/write strobes, address and write data, and consumes its read data.
- Performs block copy (read then write per byte) or block fill (write only) of up to 255 bytes.
- Frees the controller from issuing per-byte load/store sequences.
- Sits beside the processor datapath; arbitration of the shared memory port is external, and the memory port is owned by this block only while busy=1.

Parameters:
- ADDR_W, 8, width of memory address, source/destination pointers and length.
- DATA_W, 8, width of memory data words.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- go  input  1  start request; sampled only in IDLE.
- fill  input  1  latched with go; 1 = fill mode, 0 = copy mode.
- src_addr  input  ADDR_W  copy source start address; latched with go.
- dst_addr  input  ADDR_W  destination start address; latched with go.
- length  input  ADDR_W  byte count; latched with go; 0 = no transfer.
- fill_value  input  DATA_W  fill byte; latched with go.
- abort  input  1  synchronous cancel of an active transfer.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle pulse on normal completion.
- mem_read  output  1  read strobe to data memory.
- mem_write  output  1  write strobe to data memory.
- mem_address  output  ADDR_W  memory address.
- mem_data_out  output  DATA_W  write data to memory.
- mem_data_in  input  DATA_W  read data from memory (combinational while mem_read=1).

Behaviour:
- Async reset (reset_n=0): state=IDLE; all outputs 0; internal pointers, count and hold register cleared. Reset mid-transfer aborts immediately with no further memory access.
- States: IDLE, READ, WRITE, DONE. Moore outputs, decoded from state and registers only.
- IDLE:
  - busy=0, strobes 0, mem_address=0, mem_data_out=0.
  - On go=1: latch all inputs.
  - If length=0: go to DONE.
  - Else if fill=1: go to WRITE.
  - Else: go to READ.
- READ (copy only):
  - mem_read=1, mem_address=src_ptr.
  - At the clock edge ending the cycle, capture mem_data_in into hold, then go to WRITE.
- WRITE:
  - mem_write=1, mem_address=dst_ptr.
  - mem_data_out=hold in copy mode, fill_value (latched) in fill mode.
  - The memory commits on the falling edge within this cycle.
  - At the rising edge ending the cycle: src_ptr+1, dst_ptr+1, count-1.
  - If count was 1: go to DONE. Else go to READ (copy) or WRITE (fill).
- DONE: done=1, busy=0, strobes 0 for exactly one cycle, then IDLE.
- mem_read and mem_write are never asserted together.
- Latency:
  - Copy of L bytes: 2L cycles busy, then 1 done cycle.
  - Fill: L busy cycles, then 1 done cycle.
  - First memory access occurs in the cycle after go is sampled.
- Pointer arithmetic is modulo 2^ADDR_W: address 255+1 wraps to 0.
- Overlapping regions: copy is strictly ascending, byte by byte. When dst>src and the regions overlap, re-reading already-written bytes is the defined result.
- go while not in IDLE (including DONE): ignored; inputs are not re-latched.
- abort=1 in READ or WRITE: next state IDLE, no done pulse. The write in a WRITE cycle that samples abort still completes, since the strobe is already active that cycle. abort is ignored in IDLE and DONE.
- go and abort both high in IDLE: go wins.
- Input changes after go is latched have no effect on the active transfer.

Test Plan:
- Copy: mem[0x10..0x13]=0xA1,0xB2,0xC3,0xD4; go, src=0x10, dst=0x40, length=4, fill=0.
  -> mem[0x40..0x43] match the source; busy high 8 cycles; done pulses once in cycle 9 after go; mem_read/mem_write alternate.
- Fill: go, dst=0x80, length=3, fill=1, fill_value=0x5A.
  -> mem[0x80..0x82]=0x5A; mem_read never asserted; busy 3 cycles; mem[0x83] unchanged.
- Wrap: copy src=0xFE, dst=0x20, length=4.
  -> reads 0xFE, 0xFF, 0x00, 0x01 in order; writes 0x20..0x23.
- Zero length and ignored go: go with length=0 -> done pulses in the next cycle, no strobes. go pulsed during an active copy -> no effect; the original transfer completes unchanged.
- Abort: length=10 copy, assert abort in the 3rd WRITE cycle.
  -> exactly 3 destination bytes written; no done pulse; IDLE next cycle; outputs 0.
- Reset: deassert reset_n mid-fill.
  -> all outputs 0 immediately without waiting for a clock edge; after release, a new go runs correctly from its own latched inputs.
